// File: rtl/led_scroll_controller.sv
// led_scroll_controller: step-timed LED pattern sequencer with
// rotate-left, rotate-right, bounce and hold modes.
// Ports: clkin/rst (async, active-high), run level, cfg_valid/
// cfg_ready handshake with cfg_pattern/cfg_mode/cfg_speed,
// leds (registered), step_pulse, state_o, dir_o.
module led_scroll_controller #(
    parameter int WIDTH    = 16,
    parameter int TICK_MAX = 50000000,
    parameter int CNT_W    = $clog2(TICK_MAX)
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_speed,
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse,
    output logic [1:0]       state_o,
    output logic             dir_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_BNC  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   leds_q, leds_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         speed_q, speed_d;
    logic               dir_q, dir_d;

    logic [31:0]        shifted;
    logic [CNT_W-1:0]   limit;
    logic               at_limit;
    logic               step;
    logic               accept;
    logic [WIDTH-1:0]   step_leds;
    logic               step_dir;

    // Step period from the latched speed; very short periods clamp
    // to two cycles so the counter always has a boundary to reach.
    always_comb begin
        shifted = 32'(TICK_MAX) >> speed_q;
        if (shifted < 32'd2) begin
            limit = CNT_W'(1);
        end else begin
            limit = CNT_W'(shifted - 32'd1);
        end
    end

    // Pattern and direction after one step in the latched mode.
    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        unique case (mode_q)
            MODE_ROL: step_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
            MODE_ROR: step_leds = {leds_q[0], leds_q[WIDTH-1:1]};
            MODE_BNC: begin
                if (leds_q == '0) begin
                    step_leds = leds_q;
                end else if (!dir_q) begin
                    if (leds_q[WIDTH-1]) begin
                        step_dir  = 1'b1;
                        step_leds = leds_q >> 1;
                    end else begin
                        step_leds = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        step_dir  = 1'b0;
                        step_leds = leds_q << 1;
                    end else begin
                        step_leds = leds_q >> 1;
                    end
                end
            end
            MODE_HOLD: step_leds = leds_q;
            default:   step_leds = leds_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        leds_d   = leds_q;
        mode_d   = mode_q;
        speed_d  = speed_q;
        dir_d    = dir_q;

        at_limit = (cnt_q == limit);
        step     = (state_q == ST_RUN) && at_limit;
        // While running, new configuration only lands on a step boundary.
        cfg_ready  = (state_q != ST_RUN) || at_limit;
        accept     = cfg_valid && cfg_ready;
        step_pulse = step;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = run ? ST_RUN : ST_HOLD;
                end
            end
            ST_RUN: begin
                if (step) begin
                    cnt_d  = '0;
                    leds_d = step_leds;
                    dir_d  = step_dir;
                    if (!run) begin
                        state_d = ST_HOLD;
                    end
                end else if (!run) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!accept && run) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new configuration overrides any shift from the same step.
        if (accept) begin
            leds_d  = cfg_pattern;
            mode_d  = cfg_mode;
            speed_d = cfg_speed;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            leds_q  <= '0;
            mode_q  <= MODE_HOLD;
            speed_q <= 3'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end

    assign leds    = leds_q;
    assign state_o = state_q;
    assign dir_o   = dir_q;

endmodule

// File: tb/tb_led_scroll_controller.sv
// Directed testbench for led_scroll_controller (WIDTH=8, TICK_MAX=8).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_led_scroll_controller;

    logic       clkin = 1'b0;
    logic       rst;
    logic       run;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_speed;
    logic [7:0] leds;
    logic       step_pulse;
    logic [1:0] state_o;
    logic       dir_o;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    led_scroll_controller #(
        .WIDTH(8),
        .TICK_MAX(8)
    ) dut (
        .clkin(clkin),
        .rst(rst),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_mode(cfg_mode),
        .cfg_speed(cfg_speed),
        .leds(leds),
        .step_pulse(step_pulse),
        .state_o(state_o),
        .dir_o(dir_o)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic do_reset();
        cfg_valid   = 1'b0;
        cfg_pattern = 8'h00;
        cfg_mode    = 2'b00;
        cfg_speed   = 3'd0;
        run         = 1'b0;
        rst         = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    // Offer a configuration for one cycle; returns at the first
    // falling edge after acceptance (counter at 0).
    task automatic load_cfg(input logic [7:0] p, input logic [1:0] m,
                            input logic [2:0] s, input logic r);
        cfg_pattern = p;
        cfg_mode    = m;
        cfg_speed   = s;
        run         = r;
        cfg_valid   = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        cfg_valid   = 1'b0;
        cfg_pattern = 8'h00;
        cfg_mode    = 2'b00;
        cfg_speed   = 3'd0;
        run         = 1'b0;
        rst         = 1'b1;
        #1;
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds: got %h expected 00", leds);
        end
        checks++;
        if (state_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00", state_o);
        end
        checks++;
        if (cfg_ready !== 1'b1 || step_pulse !== 1'b0 || dir_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b pulse=%b dir=%b expected 1 0 0",
                     cfg_ready, step_pulse, dir_o);
        end
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (leds !== 8'h00 || state_o !== 2'b00 ||
                step_pulse !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle[%0d]: got leds=%h st=%b pulse=%b rdy=%b expected 00 00 0 1",
                         i, leds, state_o, step_pulse, cfg_ready);
            end
            cyc(1);
        end
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp;
        do_reset();
        load_cfg(8'h01, 2'b00, 3'd0, 1'b1);
        exp = 8'h01;
        checks++;
        if (leds !== exp || state_o !== 2'b01) begin
            errors++;
            $display("FAIL rol_load: got leds=%h st=%b expected 01 01", leds, state_o);
        end
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (step_pulse !== (c == 7)) begin
                    errors++;
                    $display("FAIL rol_pulse[%0d.%0d]: got %b expected %b",
                             s, c, step_pulse, (c == 7));
                end
                cyc(1);
            end
            exp = {exp[6:0], exp[7]};
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("FAIL rol_leds[%0d]: got %h expected %h", s, leds, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] bexp [9];
        logic       bdir [9];
        bexp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        bdir = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        load_cfg(8'h40, 2'b10, 3'd0, 1'b1);
        for (int s = 0; s < 9; s++) begin
            cyc(7);
            checks++;
            if (step_pulse !== 1'b1) begin
                errors++;
                $display("FAIL bnc_pulse[%0d]: got %b expected 1", s, step_pulse);
            end
            cyc(1);
            checks++;
            if (leds !== bexp[s] || dir_o !== bdir[s]) begin
                errors++;
                $display("FAIL bnc_step[%0d]: got leds=%h dir=%b expected %h %b",
                         s, leds, dir_o, bexp[s], bdir[s]);
            end
        end
    endtask

    task automatic test_speed();
        logic [2:0] spd [2];
        spd = '{3'd2, 3'd7};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            load_cfg(8'h01, 2'b11, spd[k], 1'b1);
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (step_pulse !== (i % 2 == 1) || cfg_ready !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL speed%0d[%0d]: got pulse=%b rdy=%b expected %b",
                             spd[k], i, step_pulse, cfg_ready, (i % 2 == 1));
                end
                cyc(1);
            end
            checks++;
            if (leds !== 8'h01) begin
                errors++;
                $display("FAIL speed%0d_hold_leds: got %h expected 01", spd[k], leds);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        load_cfg(8'h01, 2'b00, 3'd0, 1'b1);
        cyc(3);
        run = 1'b0;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (state_o !== 2'b10 || step_pulse !== 1'b0 ||
                leds !== 8'h01 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL freeze[%0d]: got st=%b pulse=%b leds=%h rdy=%b expected 10 0 01 1",
                         i, state_o, step_pulse, leds, cfg_ready);
            end
            cyc(1);
        end
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            checks++;
            if (step_pulse !== (i == 5) || state_o !== 2'b01) begin
                errors++;
                $display("FAIL resume[%0d]: got pulse=%b st=%b expected %b 01",
                         i, step_pulse, state_o, (i == 5));
            end
        end
        cyc(1);
        checks++;
        if (leds !== 8'h02) begin
            errors++;
            $display("FAIL resume_leds: got %h expected 02", leds);
        end
    endtask

    task automatic test_run_fall_boundary();
        do_reset();
        load_cfg(8'h01, 2'b00, 3'd0, 1'b1);
        cyc(7);
        run = 1'b0;
        checks++;
        if (step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL fall_pulse: got %b expected 1", step_pulse);
        end
        cyc(1);
        checks++;
        if (leds !== 8'h02 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL fall_step: got leds=%h st=%b expected 02 10", leds, state_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_cfg(8'h01, 2'b00, 3'd0, 1'b1);
        cyc(2);
        cfg_pattern = 8'hA5;
        cfg_mode    = 2'b00;
        cfg_speed   = 3'd0;
        cfg_valid   = 1'b1;
        for (int i = 2; i < 7; i++) begin
            checks++;
            if (cfg_ready !== 1'b0 || step_pulse !== 1'b0 || leds !== 8'h01) begin
                errors++;
                $display("FAIL wait_ready[%0d]: got rdy=%b pulse=%b leds=%h expected 0 0 01",
                         i, cfg_ready, step_pulse, leds);
            end
            cyc(1);
        end
        checks++;
        if (cfg_ready !== 1'b1 || step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL boundary_accept: got rdy=%b pulse=%b expected 1 1",
                     cfg_ready, step_pulse);
        end
        cyc(1);
        cfg_valid = 1'b0;
        checks++;
        if (leds !== 8'hA5 || state_o !== 2'b01 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_noshift: got leds=%h st=%b rdy=%b expected a5 01 0",
                     leds, state_o, cfg_ready);
        end
        cyc(7);
        checks++;
        if (step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL post_accept_pulse: got %b expected 1", step_pulse);
        end
        cyc(1);
        checks++;
        if (leds !== 8'h4B) begin
            errors++;
            $display("FAIL post_accept_leds: got %h expected 4b", leds);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_cfg(8'h01, 2'b00, 3'd0, 1'b1);
        cyc(10);
        checks++;
        if (leds !== 8'h02) begin
            errors++;
            $display("FAIL pre_areset_leds: got %h expected 02", leds);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== 8'h00 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got leds=%h st=%b expected 00 00", leds, state_o);
        end
        checks++;
        if (step_pulse !== 1'b0 || cfg_ready !== 1'b1 || dir_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: got pulse=%b rdy=%b dir=%b expected 0 1 0",
                     step_pulse, cfg_ready, dir_o);
        end
        cyc(1);
        rst = 1'b0;
        cyc(2);
        checks++;
        if (state_o !== 2'b00 || leds !== 8'h00) begin
            errors++;
            $display("FAIL after_reset_idle: got st=%b leds=%h expected 00 00", state_o, leds);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_rotate_left();
        test_bounce();
        test_speed();
        test_freeze();
        test_run_fall_boundary();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
